// File: rtl/soc_mem_pkg.sv
// Shared types and constants for the SoC SRAM initiator controller.
package soc_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACCESS  = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_RESP    = 3'd4
   } mem_state_e;

   localparam int RAM_AW   = 22;
   localparam int BYTE_OFS = 2;

endpackage

// File: rtl/soc_mem_addr_decode.sv
// Byte-address window decode and word-index conversion for the SRAM window.
module soc_mem_addr_decode
   import soc_mem_pkg::*;
#(
   parameter int unsigned WORDS     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic [31:0]       mem_addr,
   output logic              in_window,
   output logic [RAM_AW-1:0] word_idx
);

   // Bounds are 33 bits wide so a window ending at 4 GiB cannot wrap to zero.
   localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] WIN_HI = WIN_LO + (33'(WORDS) << BYTE_OFS);

   logic [31:0] byte_ofs;

   always_comb begin
      in_window = ({1'b0, mem_addr} >= WIN_LO) && ({1'b0, mem_addr} < WIN_HI);
      byte_ofs  = mem_addr - BASE_ADDR;
      word_idx  = RAM_AW'(byte_ofs >> BYTE_OFS);
   end

endmodule

// File: rtl/soc_mem_ctrl.sv
// CPU native-bus to single-port SRAM controller with optional wait states.
// All outputs are registered; out-of-window requests complete with mem_err.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for mem_valid; captures the request
// ST_ACCESS  | ram_ena high for this single cycle
// ST_WAIT    | wait-state down-counter running, terminal count at 0
// ST_CAPTURE | read data latched, mem_ready registered
// ST_RESP    | mem_ready high; mem_valid ignored (master still holds it)
module soc_mem_ctrl
   import soc_mem_pkg::*;
#(
   parameter int unsigned WORDS       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   input  logic [3:0]        mem_wstrb,
   output logic              mem_ready,
   output logic [31:0]       mem_rdata,
   output logic              mem_err,
   output logic              ram_ena,
   output logic [3:0]        ram_wen,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   mem_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              is_rd_q, is_rd_d;
   logic              mem_ready_q, mem_ready_d;
   logic              mem_err_q, mem_err_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              ram_ena_q, ram_ena_d;
   logic [3:0]        ram_wen_q, ram_wen_d;
   logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;

   logic              in_window;
   logic [RAM_AW-1:0] word_idx;

   soc_mem_addr_decode #(
      .WORDS     (WORDS),
      .BASE_ADDR (BASE_ADDR)
   ) u_decode (
      .mem_addr  (mem_addr),
      .in_window (in_window),
      .word_idx  (word_idx)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_rd_d     = is_rd_q;
      mem_ready_d = 1'b0;
      mem_err_d   = 1'b0;
      mem_rdata_d = mem_rdata_q;
      ram_ena_d   = 1'b0;
      ram_wen_d   = 4'h0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (mem_valid) begin
               if (in_window) begin
                  ram_ena_d   = 1'b1;
                  ram_wen_d   = mem_wstrb;
                  ram_addr_d  = word_idx;
                  ram_wdata_d = mem_wdata;
                  is_rd_d     = (mem_wstrb == 4'h0);
                  state_d     = ST_ACCESS;
               end else begin
                  mem_ready_d = 1'b1;
                  mem_err_d   = 1'b1;
                  state_d     = ST_RESP;
               end
            end
         end
         ST_ACCESS: begin
            if (WAIT_STATES == 0) begin
               state_d = ST_CAPTURE;
            end else begin
               cnt_d   = WS_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_CAPTURE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_CAPTURE: begin
            if (is_rd_q) begin
               mem_rdata_d = ram_rdata;
            end
            mem_ready_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         is_rd_q     <= 1'b0;
         mem_ready_q <= 1'b0;
         mem_err_q   <= 1'b0;
         mem_rdata_q <= 32'h0;
         ram_ena_q   <= 1'b0;
         ram_wen_q   <= 4'h0;
         ram_addr_q  <= '0;
         ram_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_rd_q     <= is_rd_d;
         mem_ready_q <= mem_ready_d;
         mem_err_q   <= mem_err_d;
         mem_rdata_q <= mem_rdata_d;
         ram_ena_q   <= ram_ena_d;
         ram_wen_q   <= ram_wen_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign mem_ready = mem_ready_q;
   assign mem_err   = mem_err_q;
   assign mem_rdata = mem_rdata_q;
   assign ram_ena   = ram_ena_q;
   assign ram_wen   = ram_wen_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_soc_mem_ctrl.sv
// Directed bench for soc_mem_ctrl: instance A has no wait states, instance B has three.
module tb_soc_mem_ctrl;

   logic clk;
   int   cyc;
   int   checks;
   int   errors;

   logic        reset_a, valid_a, ready_a, err_a, ena_a;
   logic [31:0] addr_a, wdata_a, rdata_a, rwdata_a, rrdata_a;
   logic [3:0]  wstrb_a, wen_a;
   logic [21:0] raddr_a;

   logic        reset_b, valid_b, ready_b, err_b, ena_b;
   logic [31:0] addr_b, wdata_b, rdata_b, rwdata_b, rrdata_b;
   logic [3:0]  wstrb_b, wen_b;
   logic [21:0] raddr_b;

   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];

   // results of the most recent txn() call
   int          t_lat, t_enas, t_ena_k, t_ena_cyc, t_rdy_cyc;
   logic [21:0] t_raddr;
   logic [3:0]  t_wen;
   logic [31:0] t_rdata;
   logic        t_err;

   soc_mem_ctrl #(.WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_a (
      .clk(clk), .reset(reset_a), .mem_valid(valid_a), .mem_addr(addr_a),
      .mem_wdata(wdata_a), .mem_wstrb(wstrb_a), .mem_ready(ready_a),
      .mem_rdata(rdata_a), .mem_err(err_a), .ram_ena(ena_a), .ram_wen(wen_a),
      .ram_addr(raddr_a), .ram_wdata(rwdata_a), .ram_rdata(rrdata_a)
   );

   soc_mem_ctrl #(.WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut_b (
      .clk(clk), .reset(reset_b), .mem_valid(valid_b), .mem_addr(addr_b),
      .mem_wdata(wdata_b), .mem_wstrb(wstrb_b), .mem_ready(ready_b),
      .mem_rdata(rdata_b), .mem_err(err_b), .ram_ena(ena_b), .ram_wen(wen_b),
      .ram_addr(raddr_b), .ram_wdata(rwdata_b), .ram_rdata(rrdata_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM models: registered read output that holds until the next read
   always @(posedge clk) begin
      if (ena_a) begin
         if (wen_a == 4'h0) rrdata_a <= mem_a[raddr_a[9:0]];
         for (int i = 0; i < 4; i++)
            if (wen_a[i]) mem_a[raddr_a[9:0]][8*i +: 8] <= rwdata_a[8*i +: 8];
      end
   end

   always @(posedge clk) begin
      if (ena_b) begin
         if (wen_b == 4'h0) rrdata_b <= mem_b[raddr_b[9:0]];
         for (int i = 0; i < 4; i++)
            if (wen_b[i]) mem_b[raddr_b[9:0]][8*i +: 8] <= rwdata_b[8*i +: 8];
      end
   end

   // Called at a negedge with the target DUT in IDLE; returns at the negedge of the RESP cycle.
   task automatic txn(input bit sel, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input bit hold);
      logic ena_s, rdy_s;
      if (sel) begin valid_b = 1'b1; addr_b = a; wdata_b = wd; wstrb_b = st; end
      else     begin valid_a = 1'b1; addr_a = a; wdata_a = wd; wstrb_a = st; end
      t_lat = 0; t_enas = 0; t_ena_k = 0; t_ena_cyc = 0; t_rdy_cyc = 0;
      t_raddr = '0; t_wen = 4'h0; t_rdata = 32'h0; t_err = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         ena_s = sel ? ena_b : ena_a;
         rdy_s = sel ? ready_b : ready_a;
         if (ena_s) begin
            t_enas++;
            t_ena_k   = k;
            t_ena_cyc = cyc;
            t_raddr   = sel ? raddr_b : raddr_a;
            t_wen     = sel ? wen_b : wen_a;
         end
         if (rdy_s) begin
            t_lat     = k;
            t_rdy_cyc = cyc;
            t_rdata   = sel ? rdata_b : rdata_a;
            t_err     = sel ? err_b : err_a;
            break;
         end
      end
      checks++;
      if (t_lat == 0) begin
         errors++;
         $display("FAIL txn_timeout addr=%h: no mem_ready within 30 cycles", a);
      end
      if (!hold) begin
         if (sel) valid_b = 1'b0; else valid_a = 1'b0;
      end
   endtask

   task automatic test_reset;
      reset_a = 1'b1; reset_b = 1'b1;
      valid_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0; wstrb_a = 4'h0;
      valid_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0; wstrb_b = 4'h0;
      repeat (3) @(negedge clk);
      checks += 7;
      if (ready_a !== 1'b0)    begin errors++; $display("FAIL reset_ready got %b want 0", ready_a); end
      if (err_a !== 1'b0)      begin errors++; $display("FAIL reset_err got %b want 0", err_a); end
      if (rdata_a !== 32'h0)   begin errors++; $display("FAIL reset_rdata got %h want 0", rdata_a); end
      if (ena_a !== 1'b0)      begin errors++; $display("FAIL reset_ena got %b want 0", ena_a); end
      if (wen_a !== 4'h0)      begin errors++; $display("FAIL reset_wen got %h want 0", wen_a); end
      if (raddr_a !== 22'h0)   begin errors++; $display("FAIL reset_raddr got %h want 0", raddr_a); end
      if (rwdata_a !== 32'h0)  begin errors++; $display("FAIL reset_rwdata got %h want 0", rwdata_a); end
      reset_a = 1'b0; reset_b = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read;
      txn(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
      checks += 6;
      if (t_lat != 3)         begin errors++; $display("FAIL wr_latency got %0d want 3", t_lat); end
      if (t_enas != 1)        begin errors++; $display("FAIL wr_ena_cycles got %0d want 1", t_enas); end
      if (t_ena_k != 1)       begin errors++; $display("FAIL wr_ena_cycle got %0d want 1", t_ena_k); end
      if (t_raddr !== 22'd4)  begin errors++; $display("FAIL wr_ram_addr got %h want 4", t_raddr); end
      if (t_wen !== 4'hF)     begin errors++; $display("FAIL wr_ram_wen got %h want f", t_wen); end
      if (t_err !== 1'b0)     begin errors++; $display("FAIL wr_err got %b want 0", t_err); end
      @(negedge clk);
      txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      checks += 5;
      if (t_lat != 3)               begin errors++; $display("FAIL rd_latency got %0d want 3", t_lat); end
      if (t_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", t_rdata); end
      if (t_err !== 1'b0)           begin errors++; $display("FAIL rd_err got %b want 0", t_err); end
      if (t_enas != 1)              begin errors++; $display("FAIL rd_ena_cycles got %0d want 1", t_enas); end
      if (t_wen !== 4'h0)           begin errors++; $display("FAIL rd_ram_wen got %h want 0", t_wen); end
      @(negedge clk);
      checks++;
      if (ready_a !== 1'b0) begin errors++; $display("FAIL ready_pulse_width got %b want 0", ready_a); end
   endtask

   task automatic test_byte_strobes;
      txn(1'b0, 32'h10, 32'h11223344, 4'b0101, 1'b0);
      checks++;
      if (t_wen !== 4'b0101) begin errors++; $display("FAIL strb_ram_wen got %h want 5", t_wen); end
      @(negedge clk);
      txn(1'b0, 32'h13, 32'h0, 4'h0, 1'b0);
      checks += 2;
      if (t_rdata !== 32'hDE22BE44) begin errors++; $display("FAIL strb_data got %h want de22be44", t_rdata); end
      if (t_raddr !== 22'd4)        begin errors++; $display("FAIL strb_low_bits_addr got %h want 4", t_raddr); end
      @(negedge clk);
   endtask

   task automatic test_out_of_window;
      logic [31:0] oow [0:1];
      oow[0] = 32'h0000_1000;
      oow[1] = 32'hFFFF_FFFC;
      for (int i = 0; i < 2; i++) begin
         txn(1'b0, oow[i], 32'h0, 4'h0, 1'b0);
         checks += 4;
         if (t_lat != 1)               begin errors++; $display("FAIL oow%0d_latency got %0d want 1", i, t_lat); end
         if (t_err !== 1'b1)           begin errors++; $display("FAIL oow%0d_err got %b want 1", i, t_err); end
         if (t_enas != 0)              begin errors++; $display("FAIL oow%0d_ena got %0d want 0", i, t_enas); end
         if (t_rdata !== 32'hDE22BE44) begin errors++; $display("FAIL oow%0d_rdata got %h want de22be44", i, t_rdata); end
         @(negedge clk);
         checks += 2;
         if (ready_a !== 1'b0) begin errors++; $display("FAIL oow%0d_ready_drop got %b want 0", i, ready_a); end
         if (err_a !== 1'b0)   begin errors++; $display("FAIL oow%0d_err_drop got %b want 0", i, err_a); end
      end
   endtask

   task automatic test_wait_states;
      txn(1'b1, 32'h14, 32'hCAFE0123, 4'hF, 1'b0);
      checks += 3;
      if (t_lat != 6)        begin errors++; $display("FAIL ws_wr_latency got %0d want 6", t_lat); end
      if (t_enas != 1)       begin errors++; $display("FAIL ws_wr_ena_cycles got %0d want 1", t_enas); end
      if (t_raddr !== 22'd5) begin errors++; $display("FAIL ws_wr_ram_addr got %h want 5", t_raddr); end
      @(negedge clk);
      txn(1'b1, 32'h14, 32'h0, 4'h0, 1'b0);
      checks += 4;
      if (t_lat != 6)               begin errors++; $display("FAIL ws_rd_latency got %0d want 6", t_lat); end
      if (t_enas != 1)              begin errors++; $display("FAIL ws_rd_ena_cycles got %0d want 1", t_enas); end
      if (t_ena_k != 1)             begin errors++; $display("FAIL ws_rd_ena_cycle got %0d want 1", t_ena_k); end
      if (t_rdata !== 32'hCAFE0123) begin errors++; $display("FAIL ws_rd_data got %h want cafe0123", t_rdata); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int ena1, enas_idle;
      txn(1'b0, 32'h24, 32'h0BADF00D, 4'hF, 1'b1);
      ena1 = t_ena_cyc;
      checks++;
      if (t_enas != 1) begin errors++; $display("FAIL b2b_first_ena got %0d want 1", t_enas); end
      txn(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
      checks += 5;
      if (t_enas != 1)                 begin errors++; $display("FAIL b2b_second_ena got %0d want 1", t_enas); end
      if (t_ena_cyc - ena1 != 4)       begin errors++; $display("FAIL b2b_ena_spacing got %0d want 4", t_ena_cyc - ena1); end
      if (t_rdy_cyc - t_ena_cyc != 2)  begin errors++; $display("FAIL b2b_ready_delay got %0d want 2", t_rdy_cyc - t_ena_cyc); end
      if (t_rdata !== 32'hDE22BE44)    begin errors++; $display("FAIL b2b_second_data got %h want de22be44", t_rdata); end
      if (t_err !== 1'b0)              begin errors++; $display("FAIL b2b_second_err got %b want 0", t_err); end
      enas_idle = 0;
      repeat (5) begin
         @(negedge clk);
         if (ena_a) enas_idle++;
      end
      checks++;
      if (enas_idle != 0) begin errors++; $display("FAIL b2b_dup_access got %0d want 0", enas_idle); end
      txn(1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
      checks++;
      if (t_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_first_write_data got %h want 0badf00d", t_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op;
      int rdy_seen;
      valid_b = 1'b1; addr_b = 32'h14; wdata_b = 32'h0; wstrb_b = 4'h0;
      repeat (3) @(negedge clk);
      reset_b = 1'b1;
      valid_b = 1'b0;
      @(negedge clk);
      checks += 7;
      if (ready_b !== 1'b0)   begin errors++; $display("FAIL rst_mid_ready got %b want 0", ready_b); end
      if (err_b !== 1'b0)     begin errors++; $display("FAIL rst_mid_err got %b want 0", err_b); end
      if (rdata_b !== 32'h0)  begin errors++; $display("FAIL rst_mid_rdata got %h want 0", rdata_b); end
      if (ena_b !== 1'b0)     begin errors++; $display("FAIL rst_mid_ena got %b want 0", ena_b); end
      if (wen_b !== 4'h0)     begin errors++; $display("FAIL rst_mid_wen got %h want 0", wen_b); end
      if (raddr_b !== 22'h0)  begin errors++; $display("FAIL rst_mid_raddr got %h want 0", raddr_b); end
      if (rwdata_b !== 32'h0) begin errors++; $display("FAIL rst_mid_rwdata got %h want 0", rwdata_b); end
      reset_b = 1'b0;
      rdy_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (ready_b) rdy_seen++;
      end
      checks++;
      if (rdy_seen != 0) begin errors++; $display("FAIL rst_mid_stray_ready got %0d want 0", rdy_seen); end
      txn(1'b1, 32'h14, 32'h0, 4'h0, 1'b0);
      checks += 2;
      if (t_lat != 6)               begin errors++; $display("FAIL rst_after_latency got %0d want 6", t_lat); end
      if (t_rdata !== 32'hCAFE0123) begin errors++; $display("FAIL rst_after_data got %h want cafe0123", t_rdata); end
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_write_read();
      test_byte_strobes();
      test_out_of_window();
      test_wait_states();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
